// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: DEPTH-entry byte FIFO that launches one byte at a time into UART_TX.
// Flags and count are registered; launches wait for tx_active low and one tx_done per byte.
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_dv_i,
    input  logic [7:0]        wr_byte_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W:0]   count_o,
    output logic              overflow_o,
    output logic              tx_dv_o,
    output logic [7:0]        tx_byte_o,
    input  logic              tx_active_i,
    input  logic              tx_done_i
);
    localparam int CW = ADDR_W + 1;

    typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE} state_t;

    state_t            state_q, state_d;
    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic              full_q, empty_q, overflow_q, tx_dv_q, tx_dv_d;
    logic [7:0]        tx_byte_q;
    logic              push, pop;

    // Writes see only the registered full flag, so a same-cycle pop never frees a slot.
    assign push    = wr_dv_i && !full_q;
    assign pop     = (state_q == IDLE) && !empty_q && !tx_active_i;
    assign count_d = count_q + CW'(push) - CW'(pop);

    always_comb begin
        state_d = state_q;
        tx_dv_d = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = pop ? SEND : IDLE;
                tx_dv_d = pop;
            end
            SEND:      state_d = WAIT_DONE;
            WAIT_DONE: state_d = tx_done_i ? IDLE : WAIT_DONE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_byte_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            tx_dv_q    <= 1'b0;
            tx_byte_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_q + ADDR_W'(push);
            rd_ptr_q   <= rd_ptr_q + ADDR_W'(pop);
            count_q    <= count_d;
            full_q     <= count_d == CW'(DEPTH);
            empty_q    <= count_d == '0;
            overflow_q <= wr_dv_i && full_q;
            tx_dv_q    <= tx_dv_d;
            if (pop) tx_byte_q <= mem_q[rd_ptr_q];
        end
    end

    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign tx_dv_o    = tx_dv_q;
    assign tx_byte_o  = tx_byte_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo with a behavioral UART_TX stub.
// The stub holds tx_active for B cycles after each launch, then pulses tx_done.
module tb_uart_tx_fifo;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int B     = 5;

    logic         clk = 1'b0, rst = 1'b1, wr_dv = 1'b0, tx_done = 1'b0, hold = 1'b0;
    logic [7:0]   wr_byte = 8'h00;
    logic         full, empty, overflow, tx_dv, tx_active;
    logic [AW:0]  count;
    logic [7:0]   tx_byte;
    int           busy = 0, cyc = 0, last_dv = -100, checks = 0, errors = 0;
    logic [7:0]   caps[$];
    int           launch_q[$], done_q[$];

    assign tx_active = hold || (busy > 0);

    uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .wr_dv_i(wr_dv), .wr_byte_i(wr_byte),
        .full_o(full), .empty_o(empty), .count_o(count), .overflow_o(overflow),
        .tx_dv_o(tx_dv), .tx_byte_o(tx_byte), .tx_active_i(tx_active), .tx_done_i(tx_done)
    );

    always #20 clk = ~clk;

    // Monitor and TX stub share one process so sampling and stub driving never race.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (tx_dv === 1'b1) begin
            checks++;
            if (cyc - last_dv < 3) begin errors++; $display("FAIL tx_dv_spacing: gap %0d cycles, need >= 3", cyc - last_dv); end
            caps.push_back(tx_byte);
            launch_q.push_back(cyc);
            last_dv = cyc;
            busy = B;
        end
        if (tx_done) done_q.push_back(cyc);
        tx_done = 1'b0;
        if (busy > 0) begin
            busy--;
            tx_done = (busy == 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic clear_logs();
        caps.delete();
        launch_q.delete();
        done_q.delete();
    endtask

    task automatic push(input logic [7:0] b);
        wr_dv = 1'b1;
        wr_byte = b;
        @(negedge clk);
        wr_dv = 1'b0;
    endtask

    task automatic wait_drain(input int n);
        int k;
        for (k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (caps.size() >= n && busy == 0 && empty) break;
        end
        checks++; if (k == 1000) begin errors++; $display("FAIL drain_timeout: got %0d bytes want %0d", caps.size(), n); end
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
        checks++; if (tx_dv !== 1'b0) begin errors++; $display("FAIL reset_tx_dv: got %b want 0", tx_dv); end
        checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL reset_tx_byte: got %h want 00", tx_byte); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        clear_logs();
        push(8'hA5);
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL single_count_after_write: got %0d want 1", count); end
        checks++; if (tx_dv !== 1'b0) begin errors++; $display("FAIL single_no_early_dv: got %b want 0", tx_dv); end
        @(negedge clk);
        checks++; if (tx_dv !== 1'b1) begin errors++; $display("FAIL single_launch: got %b want 1", tx_dv); end
        checks++; if (tx_byte !== 8'hA5) begin errors++; $display("FAIL single_tx_byte: got %h want a5", tx_byte); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL single_count_after_pop: got %0d want 0", count); end
        @(negedge clk);
        checks++; if (tx_dv !== 1'b0) begin errors++; $display("FAIL single_pulse_width: got %b want 0", tx_dv); end
        wait_drain(1);
        checks++; if (caps.size() != 1 || caps[0] !== 8'hA5) begin errors++; $display("FAIL single_output: got %0d bytes first %h want 1 byte a5", caps.size(), caps[0]); end
        checks++; if (empty !== 1'b1 || count !== 5'd0) begin errors++; $display("FAIL single_drained: got empty %b count %0d want 1 0", empty, count); end
    endtask

    task automatic test_burst();
        logic [AW:0] exp_cnt [4] = '{5'd1, 5'd1, 5'd2, 5'd3};
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            push(8'(i + 1));
            checks++; if (count !== exp_cnt[i]) begin errors++; $display("FAIL burst_count_%0d: got %0d want %0d", i, count, exp_cnt[i]); end
        end
        wait_drain(4);
        checks++; if (caps.size() != 4) begin errors++; $display("FAIL burst_pulses: got %0d want 4", caps.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (caps[i] !== 8'(i + 1)) begin errors++; $display("FAIL burst_order_%0d: got %h want %h", i, caps[i], 8'(i + 1)); end
        end
        for (int i = 1; i < 4; i++) begin
            checks++; if (launch_q[i] != done_q[i-1] + 1) begin errors++; $display("FAIL burst_done_to_launch_%0d: got launch %0d done %0d want done+1", i, launch_q[i], done_q[i-1]); end
        end
    endtask

    task automatic test_fill();
        clear_logs();
        hold = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            push(8'(i));
            checks++; if (count !== 5'(i) || full !== (i == 16)) begin errors++; $display("FAIL fill_%0d: got count %0d full %b want %0d %b", i, count, full, i, i == 16); end
        end
        push(8'd17);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow: got %b want 1", overflow); end
        checks++; if (count !== 5'd16 || full !== 1'b1) begin errors++; $display("FAIL fill_hold_count: got count %0d full %b want 16 1", count, full); end
        @(negedge clk);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_overflow_width: got %b want 0", overflow); end
        hold = 1'b0;
        wait_drain(16);
        checks++; if (caps.size() != 16) begin errors++; $display("FAIL fill_drain_size: got %0d want 16", caps.size()); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (caps[i] !== 8'(i + 1)) begin errors++; $display("FAIL fill_drain_%0d: got %h want %h", i, caps[i], 8'(i + 1)); end
        end
    endtask

    task automatic test_wrap();
        int n = 0;
        clear_logs();
        for (int g = 0; g < 2000 && n < 40; g++) begin
            if (!full) begin
                push(8'(n));
                n++;
            end else @(negedge clk);
        end
        wait_drain(40);
        checks++; if (caps.size() != 40) begin errors++; $display("FAIL wrap_size: got %0d want 40", caps.size()); end
        for (int i = 0; i < 40; i++) begin
            checks++; if (caps[i] !== 8'(i)) begin errors++; $display("FAIL wrap_%0d: got %h want %h", i, caps[i], 8'(i)); end
        end
    endtask

    task automatic test_simul();
        clear_logs();
        hold = 1'b1;
        for (int i = 0; i < 5; i++) push(8'h50 + 8'(i));
        checks++; if (count !== 5'd5) begin errors++; $display("FAIL simul_setup_count: got %0d want 5", count); end
        hold = 1'b0;
        push(8'h55);
        checks++; if (tx_dv !== 1'b1 || tx_byte !== 8'h50) begin errors++; $display("FAIL simul_launch: got dv %b byte %h want 1 50", tx_dv, tx_byte); end
        checks++; if (count !== 5'd5) begin errors++; $display("FAIL simul_count: got %0d want 5", count); end
        wait_drain(6);
        for (int i = 0; i < 6; i++) begin
            checks++; if (caps[i] !== 8'h50 + 8'(i)) begin errors++; $display("FAIL simul_order_%0d: got %h want %h", i, caps[i], 8'h50 + 8'(i)); end
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        clear_logs();
        for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
        #5 rst = 1'b1;
        #1;
        checks++; if (tx_dv !== 1'b0 || tx_byte !== 8'h00) begin errors++; $display("FAIL rstmid_tx: got dv %b byte %h want 0 00", tx_dv, tx_byte); end
        checks++; if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL rstmid_flags: got count %0d empty %b full %b ovf %b want 0 1 0 0", count, empty, full, overflow); end
        @(negedge clk);
        rst = 1'b0;
        n0 = launch_q.size();
        repeat (10) @(negedge clk);
        checks++; if (launch_q.size() != n0 || count !== 5'd0) begin errors++; $display("FAIL rstmid_no_launch: got %0d launches count %0d want %0d 0", launch_q.size(), count, n0); end
        hold = 1'b1;
        push(8'h77);
        repeat (3) @(negedge clk);
        checks++; if (launch_q.size() != n0) begin errors++; $display("FAIL rstmid_busy_guard: got %0d launches want %0d", launch_q.size(), n0); end
        hold = 1'b0;
        @(negedge clk);
        checks++; if (tx_dv !== 1'b1 || tx_byte !== 8'h77) begin errors++; $display("FAIL rstmid_relaunch: got dv %b byte %h want 1 77", tx_dv, tx_byte); end
        wait_drain(n0 + 1);
        checks++; if (count !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL rstmid_drained: got count %0d empty %b want 0 1", count, empty); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_fill();
        test_wrap();
        test_simul();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte buffer and launch controller sitting directly upstream of `UART_TX`. It accepts bytes from a producer in single-cycle write strobes and stores them in a DEPTH-entry circular FIFO. It drains the FIFO into `UART_TX` one byte at a time, using that block's `rx_dv`/`rx_byte` launch handshake and its `tx_active`/`tx_done` status. This lets loopback and command logic push bursts without tracking UART timing.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, at least 2.
- `ADDR_W`, 4: pointer width; must equal log2(`DEPTH`).
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `wr_dv`  in  1  write strobe; one byte accepted per cycle when high.
- `wr_byte`  in  8  data written when `wr_dv`=1.
- `full`  out  1  count == `DEPTH`.
- `empty`  out  1  count == 0.
- `count`  out  `ADDR_W`+1  number of stored bytes, 0..`DEPTH`.
- `overflow`  out  1  one-cycle pulse when a write is dropped.
- `tx_dv`  out  1  connects to `UART_TX.rx_dv`; one-cycle launch pulse.
- `tx_byte`  out  8  connects to `UART_TX.rx_byte`; held stable from launch until the next launch.
- `tx_active`  in  1  from `UART_TX.tx_active`.
- `tx_done`  in  1  from `UART_TX.tx_done`; one-cycle pulse after the stop bit.

## Operation
- **Storage:** 8-bit × `DEPTH` register array, write pointer `wr_ptr` and read pointer `rd_ptr` (each `ADDR_W` bits), and a registered `count`. Pointers wrap modulo `DEPTH` through natural overflow.
- **Write:** when `wr_dv`=1 and `full`=0, store the byte at `wr_ptr` and increment `wr_ptr`.
- **Write while full:** when `wr_dv`=1 and `full`=1, drop the byte and pulse `overflow` for 1 cycle. Pointers and `count` do not change.
- **Full is registered:** `full` is the registered flag. A pop in the same cycle does not make room for a write issued while `full`=1, so that write is still dropped.
- **Pop:** occurs only at the launch transition (see FSM). It reads `mem[rd_ptr]` into `tx_byte` and increments `rd_ptr`.
- **Count update:**
  - write only: +1
  - pop only: −1
  - write and pop together: unchanged
  - `count` never exceeds `DEPTH` and never goes below 0.
- **FSM** (3 states):
  - **IDLE:** if `empty`=0 and `tx_active`=0, pop, set `tx_dv`<=1, and go to SEND. Otherwise remain in IDLE.
  - **SEND:** set `tx_dv`<=0 and go to WAIT_DONE. This guarantees exactly one launch pulse per byte.
  - **WAIT_DONE:** remain until `tx_done`=1, then go to IDLE. `tx_active` is ignored in this state.
- **Reset** (asynchronous, any state, including mid-byte):
  - pointers = 0, `count` = 0, state = IDLE, `tx_dv` = 0, `tx_byte` = 8'h00, `overflow` = 0.
  - Consequently `empty` = 1 and `full` = 0.
  - Stored data is discarded. The array contents need no reset.
- **After reset with `UART_TX` still busy:** `UART_TX` is not reset by this block. If it is still shifting, the IDLE guard on `tx_active` prevents a launch until it finishes.

## Timing
- **Write visibility:** a write at edge N is reflected in `count`/`empty`/`full` after edge N.
- **First-byte latency:** with the FIFO empty and the FSM in IDLE, a write at edge N gives `tx_dv`=1 after edge N+1, for exactly 1 cycle.
- **Byte-to-byte latency:** `tx_done` sampled at edge E leads to the next launch at edge E+1, provided the FIFO is non-empty and `tx_active`=0.
- **Launch rate:** at most one `tx_dv` pulse per `tx_done` pulse. Two `tx_dv` pulses are never separated by fewer than 3 cycles.
- **Overflow pulse:** `overflow` asserts the cycle after the offending edge and lasts 1 cycle per dropped byte.
- **Output registration:** all outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- **Single byte:** `CLKS_PER_BIT`=217, 40 ns clock, bench wires this block to `UART_TX`. Write 8'hA5 once.
  - `tx_dv` pulses 1 cycle after the write.
  - Serial line shows start, then 1,0,1,0,0,1,0,1 LSB-first, then stop, at 8680 ns per bit.
  - `count` returns to 0 and `empty`=1.
- **Burst:** write 8'h01..8'h04 on 4 consecutive cycles.
  - `count` peaks at 3 (the first byte pops immediately).
  - Bytes appear on the line in order 01, 02, 03, 04.
  - Exactly 4 `tx_dv` pulses, each 1 cycle after the preceding `tx_done`.
- **Fill and overflow:** hold `tx_active`=1 with a stub TX and write 17 bytes, `DEPTH`=16.
  - `full`=1 after the 16th write.
  - 17th write gives `overflow`=1 for 1 cycle; `count` stays 16.
  - Draining yields bytes 1..16 only.
- **Wrap-around:** write and drain 40 bytes (values 0..39) through `DEPTH`=16 → output sequence 0..39 with no loss or reordering.
- **Simultaneous write and pop:** with `count`=5, issue a write on the launch cycle → `count` stays 5 and the new byte is last in output order.
- **Reset mid-transmission:** assert `rst` during WAIT_DONE with 3 bytes queued.
  - Outputs go to their reset values immediately (asynchronously).
  - No further `tx_dv` occurs until a new write arrives and `tx_active`=0.
